// File: rtl/sipo_collector.sv
// sipo_collector: serial-in, parallel-out word collector.
// Rebuilds WIDTH-bit words from a start-framed serial stream and offers them
// downstream on a valid/ready handshake. Dropped words raise `overrun` and
// mid-frame starts raise `abort_err`. Both flags are sticky until `clr`.
// Build option: define SIPO_MSB_FIRST_EN to receive the stream MSB-first;
// the default build receives LSB-first.

module sipo_collector #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in,
    input  logic             ready,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic             abort_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;

    logic [CW-1:0]    pos;
    logic [CW-1:0]    bit_idx;
    logic [WIDTH-1:0] word_next;
    logic             complete;
    logic             accept;
    logic             load;
    logic             drop_evt;
    logic             abort_evt;

    // Next assembled word, completion and error events for the coming edge
    always_comb begin
        // A start always places the current bit at stream position 0 and
        // throws away whatever partial word was being built.
        pos = (state == SHIFT && !start) ? cnt : '0;
`ifdef SIPO_MSB_FIRST_EN
        bit_idx = LAST - pos;
`else
        bit_idx = pos;
`endif
        word_next          = start ? '0 : sreg;
        word_next[bit_idx] = in;

        complete  = (state == SHIFT) && !start && (cnt == LAST);
        accept    = valid && ready;
        load      = complete && (!valid || ready);
        drop_evt  = complete && valid && !ready;
        abort_evt = (state == SHIFT) && start;
    end

    // Frame FSM, output holding register, handshake and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            out       <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            abort_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        cnt   <= ONE;
                        sreg  <= word_next;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        cnt  <= ONE;
                        sreg <= word_next;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        sreg  <= '0;
                    end else begin
                        cnt  <= cnt + ONE;
                        sreg <= word_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    sreg  <= '0;
                end
            endcase

            // A completed word may replace one being accepted in the same cycle.
            if (load) begin
                out   <= word_next;
                valid <= 1'b1;
            end else if (accept) begin
                valid <= 1'b0;
            end

            // A new event outranks a simultaneous clear.
            overrun   <= drop_evt  | (overrun   & ~clr);
            abort_err <= abort_evt | (abort_err & ~clr);
        end
    end

endmodule

// File: tb/tb_sipo_collector.sv
// tb_sipo_collector: randomized and directed stimulus for sipo_collector,
// checked against a frame-level reference model through a word scoreboard.

module tb_sipo_collector;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             in;
    logic             ready;
    logic             clr;
    logic [WIDTH-1:0] out;
    logic             valid;
    logic             busy;
    logic             overrun;
    logic             abort_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sipo_collector #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in       (in),
        .ready    (ready),
        .clr      (clr),
        .out      (out),
        .valid    (valid),
        .busy     (busy),
        .overrun  (overrun),
        .abort_err(abort_err)
    );

    // Reference model: a frame is a list of received bits; a word exists once
    // the list holds WIDTH bits. A single holding slot models the output.
    bit               frame[$];
    bit               m_in_frame;
    logic [WIDTH-1:0] m_out;
    bit               m_valid;
    bit               m_ovr;
    bit               m_abort;
    logic [WIDTH-1:0] sb[$];

    function automatic logic [WIDTH-1:0] assemble();
        logic [WIDTH-1:0] w = '0;
        for (int k = 0; k < WIDTH; k++) begin
`ifdef SIPO_MSB_FIRST_EN
            w[WIDTH-1-k] = frame[k];
`else
            w[k] = frame[k];
`endif
        end
        return w;
    endfunction

    task automatic model_reset();
        frame.delete();
        m_in_frame = 1'b0;
        m_out      = '0;
        m_valid    = 1'b0;
        m_ovr      = 1'b0;
        m_abort    = 1'b0;
        sb.delete();
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        bit ab = 1'b0;
        bit ov = 1'b0;
        bit done = 1'b0;
        logic [WIDTH-1:0] w = '0;
        if (start) begin
            ab = m_in_frame;
            frame.delete();
            frame.push_back(in);
            m_in_frame = 1'b1;
        end else if (m_in_frame) begin
            frame.push_back(in);
        end
        if (m_in_frame && frame.size() == WIDTH) begin
            done = 1'b1;
            w = assemble();
            frame.delete();
            m_in_frame = 1'b0;
        end
        if (done) begin
            if (!m_valid || ready) begin
                m_out   = w;
                m_valid = 1'b1;
                sb.push_back(w);
            end else begin
                ov = 1'b1;
            end
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        m_ovr   = ov || (m_ovr && !clr);
        m_abort = ab || (m_abort && !clr);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare registered outputs against the model and pop the
    // scoreboard whenever the DUT hands a word downstream.
    always @(negedge clk) begin
        logic [WIDTH-1:0] w;
        check_bit("valid", valid, m_valid);
        check_bit("busy", busy, m_in_frame);
        check_bit("overrun", overrun, m_ovr);
        check_bit("abort_err", abort_err, m_abort);
        check_word("out", out, m_out);
        if (!reset && valid && ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_pop @%0t: got word %h expected no word", $time, out);
            end else begin
                w = sb.pop_front();
                check_word("sb_word", out, w);
            end
        end
    end

    task automatic cycle(input bit s, input bit i, input bit r, input bit c);
        @(posedge clk);
        #1;
        model_step();
        #1;
        start = s;
        in    = i;
        ready = r;
        clr   = c;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input bit r);
        for (int k = 0; k < WIDTH; k++) begin
            cycle(k == 0, w[k], r, 1'b0);
        end
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #1;
        model_step();
        #1;
        reset = 1'b1;
        start = 1'b0;
        in    = 1'b0;
        ready = 1'b0;
        clr   = 1'b0;
        model_reset();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in    = 1'b0;
        ready = 1'b0;
        clr   = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Basic receive: 0xA5, visible exactly WIDTH cycles after start
        send_frame(8'hA5, 1'b1);
        #2;
        check_bit("basic_not_early", valid, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        check_word("basic_out", out, 8'hA5);
        check_bit("basic_valid", valid, 1'b1);
        check_bit("basic_busy", busy, 1'b0);

        // Back-to-back frames with no gap
        send_frame(8'h01, 1'b1);
        send_frame(8'hFE, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        #2;
`ifdef SIPO_MSB_FIRST_EN
        check_word("b2b_out", out, 8'h7F);
`else
        check_word("b2b_out", out, 8'hFE);
`endif
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun: second word is dropped while the first is held
        send_frame(8'h3C, 1'b0);
        send_frame(8'hC3, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check_word("ovr_hold", out, 8'h3C);
        check_bit("ovr_flag", overrun, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check_bit("ovr_accepted", valid, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check_bit("ovr_cleared", overrun, 1'b0);

        // Abort: three bits, then a fresh start carrying 0x5A
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        check_bit("abort_flag", abort_err, 1'b1);
        check_word("abort_out", out, 8'h5A);

        // Reset mid-frame clears everything immediately
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        assert_reset();
        #1;
        check_word("rst_out", out, '0);
        check_bit("rst_valid", valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_abort", abort_err, 1'b0);
        release_reset();
        send_frame(8'h81, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        check_word("rst_next", out, 8'h81);

        // Bit order: a single leading 1 lands at bit 0 or at bit WIDTH-1
        send_frame(8'h01, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        #2;
`ifdef SIPO_MSB_FIRST_EN
        check_word("order_out", out, 8'h80);
`else
        check_word("order_out", out, 8'h01);
`endif

        // Randomized traffic: frames, aborts, backpressure, clears, resets
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: send_frame(WIDTH'($urandom), 1'($urandom_range(0, 1)));
                1: begin
                    if ($urandom_range(0, 19) == 0) begin
                        assert_reset();
                        release_reset();
                    end else begin
                        cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
                    end
                end
                default: begin
                    for (int k = 0; k < 5; k++) begin
                        cycle($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                              $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
                    end
                end
            endcase
        end

        repeat (2 * WIDTH) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #6;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
